spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Transaction-level scheduler in front of the bit-serial SPI master engine (CMD/ADDR/DUMMY/DATA shifter).
- Shares the single engine between two requesters: requester 0 is the stimulus-ROM sequencer, requester 1 is the host/debug port.
- Accepts complete {cmd, addr, data} transactions and launches them one at a time. Returns read data or an error per transaction, with round-robin fairness and a completion watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024: WAIT-state cycles allowed before the engine is aborted; legal range 2..65535.
- CNT_W, 8: width of the saturating completed-transaction counter.

Ports:
- clk_i  in  1  block clock; the divided SPI-domain clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  2  per-requester transaction request; bit n belongs to requester n.
- req_ready_o  out  2  one-cycle accept pulse to the granted requester.
- req0_cmd_i  in  8  requester 0 command byte.
- req0_addr_i  in  32  requester 0 address.
- req0_data_i  in  32  requester 0 write data.
- req1_cmd_i  in  8  requester 1 command byte.
- req1_addr_i  in  32  requester 1 address.
- req1_data_i  in  32  requester 1 write data.
- rsp_valid_o  out  2  one-cycle completion pulse to the owning requester.
- rsp_data_o  out  32  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  error flag (illegal command or timeout), valid with rsp_valid_o.
- eng_start_o  out  1  one-cycle launch pulse to the engine.
- eng_abort_o  out  1  one-cycle abort pulse; the engine returns to IDLE and raises CS.
- eng_cmd_o  out  8  latched command.
- eng_addr_o  out  32  latched address.
- eng_data_o  out  32  latched write data.
- eng_done_i  in  1  engine completion pulse.
- eng_rdata_i  in  32  engine read data, valid with eng_done_i.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- owner_o  out  1  index of the current or last granted requester.
- txn_count_o  out  CNT_W  number of completed transactions, saturating.

Behaviour:
- Reset: the async reset forces all outputs, eng_* payload registers, timer and counter to 0, and the FSM to IDLE.
  - Internal last_grant resets to 1, so requester 0 wins the first tie.
  - A reset mid-transaction drops the transaction silently; no rsp_valid_o is issued.
- Legal commands: 0x01 write reg, 0x02 write mem, 0x07 read reg, 0x0B read mem. Anything else is illegal.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If exactly one req_valid_i bit is set, grant that requester.
  - If both bits are set, grant the requester that is not last_grant.
  - On grant: pulse req_ready_o[g], latch cmd/addr/data into eng_*_o, set owner_o=g.
  - Legal cmd: go to LAUNCH. Illegal cmd: go to RESP with err=1 and data=0; no engine activity.
- LAUNCH: eng_start_o=1 for one cycle, timer cleared, then go to WAIT.
- WAIT: timer increments each cycle.
  - eng_done_i=1: latch rsp data, then go to RESP with err=0.
    - rsp data = eng_rdata_i for 0x07/0x0B.
    - rsp data = 0 for writes.
  - Otherwise, if timer==TIMEOUT_CYCLES-1: pulse eng_abort_o, go to RESP with err=1 and data=0.
  - If eng_done_i and timeout coincide, done wins: no abort, err=0.
- RESP:
  - rsp_valid_o[owner]=1 for one cycle.
  - rsp_data_o and rsp_err_o are held until the next RESP.
  - txn_count_o increments; errored transactions also count; it saturates at all-ones.
  - last_grant=owner, then go to IDLE.
- Latency:
  - Accept at cycle N, eng_start_o at N+1.
  - eng_done_i at cycle M gives rsp_valid_o at M+1.
  - Next accept no earlier than M+2.
  - Illegal command: accept at N, rsp_valid_o at N+1.
- Handshake rules:
  - Requesters hold req_valid_i and payload until req_ready_o.
  - Dropping req_valid_i before the accept is legal; nothing is issued.
  - Payload changes after the accept are ignored.
- Ignored inputs:
  - eng_done_i outside WAIT, including in the cycle of eng_start_o.
  - req_valid_i outside IDLE.
- eng_*_o payload stays stable from the accept until the next accept.

Test Plan:
- Single read: req0 cmd=0x0B addr=0x10 → eng_start_o at accept+1. eng_done_i with rdata=0xDEADBEEF → rsp_valid_o=2'b01, rsp_data_o=0xDEADBEEF, err=0, txn_count_o=1.
- Contention: both requesters valid continuously, four transactions each completing in 5 cycles → grant order 0,1,0,1; rsp_valid_o alternates 01/10.
- Illegal cmd: req1 cmd=0x55 → req_ready_o=10, then next cycle rsp_valid_o=10, err=1, data=0; eng_start_o never asserted.
- Timeout: TIMEOUT_CYCLES=8, write 0x02, no eng_done_i → eng_abort_o on the 8th WAIT cycle, rsp err=1. Repeat with eng_done_i on that same cycle → err=0, no abort.
- Reset in WAIT: assert rst_i asynchronously → all outputs 0, no rsp_valid_o; after release, both requesters valid → requester 0 granted first.
- Saturation: CNT_W=2, five completed transactions → txn_count_o stays 3.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// rtl/spi_txn_arbiter_if.sv - requester, response and engine signals of the SPI transaction arbiter
interface spi_txn_arbiter_if #(
    parameter int CNT_W = 8
) ();
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [7:0]       req0_cmd_i;
    logic [31:0]      req0_addr_i;
    logic [31:0]      req0_data_i;
    logic [7:0]       req1_cmd_i;
    logic [31:0]      req1_addr_i;
    logic [31:0]      req1_data_i;
    logic [1:0]       rsp_valid_o;
    logic [31:0]      rsp_data_o;
    logic             rsp_err_o;
    logic             eng_start_o;
    logic             eng_abort_o;
    logic [7:0]       eng_cmd_o;
    logic [31:0]      eng_addr_o;
    logic [31:0]      eng_data_o;
    logic             eng_done_i;
    logic [31:0]      eng_rdata_i;
    logic             busy_o;
    logic             owner_o;
    logic [CNT_W-1:0] txn_count_o;

    modport slave (
        input  req_valid_i, req0_cmd_i, req0_addr_i, req0_data_i,
               req1_cmd_i, req1_addr_i, req1_data_i, eng_done_i, eng_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               eng_start_o, eng_abort_o, eng_cmd_o, eng_addr_o, eng_data_o,
               busy_o, owner_o, txn_count_o
    );

    modport master (
        output req_valid_i, req0_cmd_i, req0_addr_i, req0_data_i,
               req1_cmd_i, req1_addr_i, req1_data_i, eng_done_i, eng_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               eng_start_o, eng_abort_o, eng_cmd_o, eng_addr_o, eng_data_o,
               busy_o, owner_o, txn_count_o
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin transaction scheduler for the shared SPI master engine
module spi_txn_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_txn_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [7:0]       cmd_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [15:0]      timer_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] txn_count_q;

    logic             grant;
    logic [7:0]       sel_cmd;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_data;
    logic             sel_legal;
    logic             accept;
    logic             eng_start;
    logic             eng_abort;
    logic             rsp_fire;
    logic             timeout_hit;

    function automatic logic cmd_legal(input logic [7:0] c);
        return (c == 8'h01) || (c == 8'h02) || (c == 8'h07) || (c == 8'h0B);
    endfunction

    function automatic logic cmd_is_read(input logic [7:0] c);
        return (c == 8'h07) || (c == 8'h0B);
    endfunction

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        case (bus.req_valid_i)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign sel_cmd     = grant ? bus.req1_cmd_i  : bus.req0_cmd_i;
    assign sel_addr    = grant ? bus.req1_addr_i : bus.req0_addr_i;
    assign sel_data    = grant ? bus.req1_data_i : bus.req0_data_i;
    assign sel_legal   = cmd_legal(sel_cmd);
    assign timeout_hit = (timer_q == TIMER_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        rsp_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid_i) begin
                    accept  = 1'b1;
                    state_d = sel_legal ? ST_LAUNCH : ST_RESP;
                end
            end
            ST_LAUNCH: begin
                eng_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the same cycle as the deadline still counts as success.
                if (bus.eng_done_i) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    eng_abort = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_fire = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cmd_q        <= 8'h00;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            timer_q      <= 16'h0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant;
                cmd_q   <= sel_cmd;
                addr_q  <= sel_addr;
                data_q  <= sel_data;
                if (!sel_legal) begin
                    rsp_data_q <= 32'h0;
                    rsp_err_q  <= 1'b1;
                end
            end

            if (state_q == ST_LAUNCH) begin
                timer_q <= 16'h0;
            end else if (state_q == ST_WAIT) begin
                timer_q <= timer_q + 16'd1;
            end

            if (state_q == ST_WAIT) begin
                if (bus.eng_done_i) begin
                    rsp_data_q <= cmd_is_read(cmd_q) ? bus.eng_rdata_i : 32'h0;
                    rsp_err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data_q <= 32'h0;
                    rsp_err_q  <= 1'b1;
                end
            end

            if (rsp_fire) begin
                last_grant_q <= owner_q;
                if (txn_count_q != {CNT_W{1'b1}}) begin
                    txn_count_q <= txn_count_q + CNT_W'(1);
                end
            end
        end
    end

    // The accept pulse is combinational, so it is masked while reset is held.
    assign bus.req_ready_o = (accept && !rst_i) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid_o = rsp_fire ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.eng_start_o = eng_start;
    assign bus.eng_abort_o = eng_abort;
    assign bus.eng_cmd_o   = cmd_q;
    assign bus.eng_addr_o  = addr_q;
    assign bus.eng_data_o  = data_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.owner_o     = owner_q;
    assign bus.txn_count_o = txn_count_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;
    localparam int TO = 8;
    localparam int CW = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    spi_txn_arbiter_if #(.CNT_W(CW)) bus ();

    spi_txn_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [7:0]  c0;
        logic [7:0]  c1;
        int          dly;
        logic [31:0] rdata;
        bit          dl;
        int          eg;
        bit          eerr;
        logic [31:0] edata;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    int lg = 1;
    int n_done = 0;
    logic [7:0] legal_cmds [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    function automatic bit is_legal(input logic [7:0] c);
        foreach (legal_cmds[k]) if (legal_cmds[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_read(input logic [7:0] c);
        return (c == 8'h07) || (c == 8'h0B);
    endfunction

    function automatic int model_grant(input logic [1:0] mask);
        if (mask == 2'b01) return 0;
        if (mask == 2'b10) return 1;
        return (lg == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] exp_count();
        int mx = (1 << CW) - 1;
        return (n_done > mx) ? mx : n_done;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, bus.req_ready_o, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data_o, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err_o, 0);
        chk({tag, "_start"}, bus.eng_start_o, 0);
        chk({tag, "_abort"}, bus.eng_abort_o, 0);
        chk({tag, "_cmd"}, bus.eng_cmd_o, 0);
        chk({tag, "_addr"}, bus.eng_addr_o, 0);
        chk({tag, "_data"}, bus.eng_data_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_owner"}, bus.owner_o, 0);
        chk({tag, "_count"}, bus.txn_count_o, 0);
    endtask

    // One complete transaction; dly is the WAIT cycle index of eng_done_i, dly>=TO means never.
    task automatic run_txn(input logic [1:0] mask,
                           input logic [7:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [7:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                           input int dly, input logic [31:0] rdata, input bit dl,
                           input int eg, input bit eerr, input logic [31:0] edata);
        logic [7:0]  gc;
        logic [31:0] ga;
        logic [31:0] gd;
        logic [1:0]  gbit;
        gc   = (eg != 0) ? c1 : c0;
        ga   = (eg != 0) ? a1 : a0;
        gd   = (eg != 0) ? d1 : d0;
        gbit = (eg != 0) ? 2'b10 : 2'b01;

        cyc();
        bus.req_valid_i = mask;
        bus.req0_cmd_i = c0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
        bus.req1_cmd_i = c1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
        smp();
        chk("accept_ready", bus.req_ready_o, gbit);
        chk("accept_busy", bus.busy_o, 0);

        cyc();
        bus.req_valid_i = mask & ~gbit;
        if (eg != 0) begin
            bus.req1_cmd_i = ~c1; bus.req1_addr_i = ~a1; bus.req1_data_i = ~d1;
        end else begin
            bus.req0_cmd_i = ~c0; bus.req0_addr_i = ~a0; bus.req0_data_i = ~d0;
        end
        bus.eng_done_i  = dl && is_legal(gc);
        bus.eng_rdata_i = 32'hBAD0_BAD0;
        if (is_legal(gc)) begin
            smp();
            chk("launch_start", bus.eng_start_o, 1);
            chk("launch_cmd", bus.eng_cmd_o, gc);
            chk("launch_addr", bus.eng_addr_o, ga);
            chk("launch_data", bus.eng_data_o, gd);
            chk("launch_owner", bus.owner_o, eg);
            chk("launch_ready", bus.req_ready_o, 0);
            for (int i = 0; i < TO; i++) begin
                cyc();
                bus.eng_done_i  = (i == dly);
                bus.eng_rdata_i = (i == dly) ? rdata : 32'hBAD0_BAD0;
                smp();
                chk("wait_abort", bus.eng_abort_o, (i == TO - 1) && (dly >= TO));
                chk("wait_rsp_valid", bus.rsp_valid_o, 0);
                chk("wait_ready", bus.req_ready_o, 0);
                if (i == dly) break;
            end
            cyc();
            bus.eng_done_i = 1'b0;
        end
        smp();
        chk("resp_valid", bus.rsp_valid_o, gbit);
        chk("resp_data", bus.rsp_data_o, edata);
        chk("resp_err", bus.rsp_err_o, eerr);
        chk("resp_start", bus.eng_start_o, 0);
        chk("resp_abort", bus.eng_abort_o, 0);
        chk("resp_cmd_stable", bus.eng_cmd_o, gc);

        cyc();
        bus.eng_done_i  = 1'b0;
        bus.req_valid_i = 2'b00;
        smp();
        n_done++;
        chk("post_count", bus.txn_count_o, exp_count());
        chk("post_busy", bus.busy_o, 0);
        chk("post_rsp_valid", bus.rsp_valid_o, 0);
        chk("post_rsp_held", bus.rsp_data_o, edata);
        lg = eg;
    endtask

    function automatic logic [7:0] pick_cmd();
        int r = $urandom_range(0, 5);
        if (r < 4) return legal_cmds[r];
        return 8'($urandom);
    endfunction

    initial begin
        vec_t vecs [12];
        legal_cmds = '{8'h01, 8'h02, 8'h07, 8'h0B};

        vecs[0]  = '{2'b01, 8'h0B, 8'h00, 2, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{2'b10, 8'h00, 8'h55, 0, 32'h0,         1'b0, 1, 1'b1, 32'h0};
        vecs[2]  = '{2'b11, 8'h0B, 8'h07, 3, 32'h1111_0000, 1'b0, 0, 1'b0, 32'h1111_0000};
        vecs[3]  = '{2'b11, 8'h01, 8'h0B, 3, 32'h2222_0000, 1'b0, 1, 1'b0, 32'h2222_0000};
        vecs[4]  = '{2'b11, 8'h02, 8'h01, 3, 32'h3333_0000, 1'b0, 0, 1'b0, 32'h0};
        vecs[5]  = '{2'b11, 8'h07, 8'h02, 3, 32'h4444_0000, 1'b0, 1, 1'b0, 32'h0};
        vecs[6]  = '{2'b11, 8'h02, 8'h01, 9, 32'h0,         1'b0, 0, 1'b1, 32'h0};
        vecs[7]  = '{2'b11, 8'h07, 8'h02, 7, 32'h5555_0000, 1'b0, 1, 1'b0, 32'h0};
        vecs[8]  = '{2'b10, 8'h00, 8'h07, 7, 32'h6666_0000, 1'b0, 1, 1'b0, 32'h6666_0000};
        vecs[9]  = '{2'b01, 8'h0B, 8'h00, 8, 32'h7777_0000, 1'b0, 0, 1'b1, 32'h0};
        vecs[10] = '{2'b11, 8'h0B, 8'h0B, 0, 32'h8888_0000, 1'b1, 1, 1'b0, 32'h8888_0000};
        vecs[11] = '{2'b11, 8'hFF, 8'h0B, 0, 32'h0,         1'b0, 0, 1'b1, 32'h0};

        rst_i = 1'b1;
        bus.req_valid_i = 2'b00;
        bus.req0_cmd_i = 8'h0; bus.req0_addr_i = 32'h0; bus.req0_data_i = 32'h0;
        bus.req1_cmd_i = 8'h0; bus.req1_addr_i = 32'h0; bus.req1_data_i = 32'h0;
        bus.eng_done_i = 1'b0;
        bus.eng_rdata_i = 32'h0;
        repeat (3) cyc();
        smp();
        check_all_zero("reset");
        cyc();
        rst_i = 1'b0;
        lg = 1;
        n_done = 0;

        for (int v = 0; v < 12; v++) begin
            run_txn(vecs[v].mask,
                    vecs[v].c0, 32'h10 + 32'(v), 32'hA5A5_0000 | 32'(v),
                    vecs[v].c1, 32'h2000 + 32'(v), 32'h5A5A_0000 | 32'(v),
                    vecs[v].dly, vecs[v].rdata, vecs[v].dl,
                    vecs[v].eg, vecs[v].eerr, vecs[v].edata);
        end

        // Reset in the middle of WAIT: requester 1 wins the tie now, requester 0 after reset.
        cyc();
        bus.req_valid_i = 2'b11;
        bus.req0_cmd_i = 8'h0B; bus.req0_addr_i = 32'h0000_0300; bus.req0_data_i = 32'h3;
        bus.req1_cmd_i = 8'h07; bus.req1_addr_i = 32'h0000_0400; bus.req1_data_i = 32'h4;
        smp();
        chk("rst_seq_ready", bus.req_ready_o, 2'b10);
        cyc();
        smp();
        chk("rst_seq_start", bus.eng_start_o, 1);
        cyc();
        smp();
        cyc();
        smp();
        #2 rst_i = 1'b1;
        #1;
        check_all_zero("mid_reset");
        for (int k = 0; k < 3; k++) begin
            cyc();
            smp();
            chk("mid_reset_rsp", bus.rsp_valid_o, 0);
            chk("mid_reset_ready", bus.req_ready_o, 0);
        end
        cyc();
        bus.req_valid_i = 2'b00;
        rst_i = 1'b0;
        lg = 1;
        n_done = 0;
        run_txn(2'b11, 8'h02, 32'h50, 32'h51, 8'h01, 32'h60, 32'h61, 1, 32'h9, 1'b0, 0, 1'b0, 32'h0);
        run_txn(2'b11, 8'h02, 32'h52, 32'h53, 8'h0B, 32'h62, 32'h63, 4, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 32'hCAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            logic [1:0]  mask;
            logic [7:0]  c0, c1, gc;
            logic [31:0] rdata, edata;
            int          dly, eg;
            bit          eerr;
            mask  = 2'($urandom_range(1, 3));
            c0    = pick_cmd();
            c1    = pick_cmd();
            dly   = $urandom_range(0, TO + 1);
            rdata = $urandom;
            eg    = model_grant(mask);
            gc    = (eg != 0) ? c1 : c0;
            eerr  = !is_legal(gc) || (dly >= TO);
            edata = (!eerr && is_read(gc)) ? rdata : 32'h0;
            run_txn(mask, c0, $urandom, $urandom, c1, $urandom, $urandom,
                    dly, rdata, 1'($urandom_range(0, 1)), eg, eerr, edata);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
